// File: rtl/lane_stripe_ctrl.sv
// lane_stripe_ctrl: collects a valid-qualified byte stream into groups of four
// and launches each group onto four aligned lane outputs in one cycle. A
// partial group at end of stream is padded with PAD_BYTE and flushed.
//
// Handshake: the input side is valid-only with no backpressure. A byte is
// consumed on every rising edge where valid=1; there is no ready signal because
// the block always accepts one byte per cycle. valid=0 while a group is
// partially filled terminates that group with a flush launch.
module lane_stripe_ctrl #(
  parameter logic [7:0] PAD_BYTE = 8'hF7,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             valid,
  output logic [7:0]       out0,
  output logic [7:0]       out1,
  output logic [7:0]       out2,
  output logic [7:0]       out3,
  output logic [3:0]       validout,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] group_cnt,
  output logic [CNT_W-1:0] pad_cnt,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] s0;
  logic [7:0] s1;
  logic [7:0] s2;

  // Raw FSM state for observation; busy carries the same information registered.
  assign state_dbg = state;

  // Group sequencer: staging writes, full/flush launches and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s0        <= 8'h00;
      s1        <= 8'h00;
      s2        <= 8'h00;
      out0      <= 8'h00;
      out1      <= 8'h00;
      out2      <= 8'h00;
      out3      <= 8'h00;
      validout  <= 4'b0000;
      sel       <= 2'd0;
      busy      <= 1'b0;
      group_cnt <= '0;
      pad_cnt   <= '0;
    end else begin
      // validout is a single-cycle pulse; only a launch raises it.
      validout <= 4'b0000;
      case (state)
        IDLE: begin
          if (valid) begin
            s0    <= in;
            sel   <= 2'd1;
            state <= FILL;
            busy  <= 1'b1;
          end
        end
        FILL: begin
          if (valid) begin
            if (sel == 2'd3) begin
              // Fourth byte bypasses staging and lands directly on lane 3.
              out0      <= s0;
              out1      <= s1;
              out2      <= s2;
              out3      <= in;
              validout  <= 4'b1111;
              group_cnt <= group_cnt + CNT_W'(1);
              sel       <= 2'd0;
            end else begin
              case (sel)
                2'd0:    s0 <= in;
                2'd1:    s1 <= in;
                default: s2 <= in;
              endcase
              sel <= sel + 2'd1;
            end
          end else begin
            // End of stream: flush any partial group, then return to IDLE.
            if (sel != 2'd0) begin
              out0      <= s0;
              out1      <= (sel >= 2'd2) ? s1 : PAD_BYTE;
              out2      <= (sel == 2'd3) ? s2 : PAD_BYTE;
              out3      <= PAD_BYTE;
              case (sel)
                2'd1:    validout <= 4'b0001;
                2'd2:    validout <= 4'b0011;
                default: validout <= 4'b0111;
              endcase
              group_cnt <= group_cnt + CNT_W'(1);
              pad_cnt   <= pad_cnt + CNT_W'(3'd4 - {1'b0, sel});
            end
            sel   <= 2'd0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          sel   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// Bench for lane_stripe_ctrl: a directed vector table for the documented
// sequences, then random traffic against a queue-based group model. A second
// instance with 4-bit counters shares the stimulus to exercise counter wrap.
module tb_lane_stripe_ctrl;

  localparam logic [7:0] PAD = 8'hF7;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in;
  logic        valid;

  always #5 clk = ~clk;

  logic [7:0]  out0, out1, out2, out3;
  logic [3:0]  validout;
  logic [1:0]  sel;
  logic        busy;
  logic [15:0] group_cnt;
  logic [15:0] pad_cnt;
  logic        state_dbg;

  logic [7:0]  n_out0, n_out1, n_out2, n_out3;
  logic [3:0]  n_validout;
  logic [1:0]  n_sel;
  logic        n_busy;
  logic [3:0]  n_group_cnt;
  logic [3:0]  n_pad_cnt;
  logic        n_state_dbg;

  lane_stripe_ctrl #(.PAD_BYTE(PAD), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in(in), .valid(valid),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .validout(validout), .sel(sel), .busy(busy),
    .group_cnt(group_cnt), .pad_cnt(pad_cnt), .state_dbg(state_dbg)
  );

  lane_stripe_ctrl #(.PAD_BYTE(PAD), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in(in), .valid(valid),
    .out0(n_out0), .out1(n_out1), .out2(n_out2), .out3(n_out3),
    .validout(n_validout), .sel(n_sel), .busy(n_busy),
    .group_cnt(n_group_cnt), .pad_cnt(n_pad_cnt), .state_dbg(n_state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];        // bytes of the group currently being collected
  logic [7:0] m_lane [4];      // last launched lane values
  logic [3:0] m_vo;
  logic       m_busy;
  int         m_groups;
  int         m_pads;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model update for one rising edge, from the grouping rules directly.
  task automatic model_edge(input logic r, input logic v, input logic [7:0] b);
    if (r) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
      m_vo = 4'b0000; m_busy = 1'b0; m_groups = 0; m_pads = 0;
    end else begin
      m_vo = 4'b0000;
      if (v) begin
        exp_q.push_back(b);
        m_busy = 1'b1;
        if (exp_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_lane[i] = exp_q[i];
          m_vo = 4'b1111;
          m_groups++;
          exp_q.delete();
        end
      end else begin
        m_busy = 1'b0;
        if (exp_q.size() > 0) begin
          int k;
          k = exp_q.size();
          for (int i = 0; i < 4; i++) m_lane[i] = (i < k) ? exp_q[i] : PAD;
          m_vo = 4'((1 << k) - 1);
          m_groups++;
          m_pads += 4 - k;
          exp_q.delete();
        end
      end
    end
  endtask

  task automatic compare_model();
    check("out0", {24'd0, out0}, {24'd0, m_lane[0]});
    check("out1", {24'd0, out1}, {24'd0, m_lane[1]});
    check("out2", {24'd0, out2}, {24'd0, m_lane[2]});
    check("out3", {24'd0, out3}, {24'd0, m_lane[3]});
    check("validout", {28'd0, validout}, {28'd0, m_vo});
    check("sel", {30'd0, sel}, 32'(exp_q.size()));
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("state_dbg", {31'd0, state_dbg}, {31'd0, m_busy});
    check("group_cnt", {16'd0, group_cnt}, 32'(m_groups & 32'hFFFF));
    check("pad_cnt", {16'd0, pad_cnt}, 32'(m_pads & 32'hFFFF));
    check("group_cnt_w4", {28'd0, n_group_cnt}, 32'(m_groups & 32'hF));
    check("pad_cnt_w4", {28'd0, n_pad_cnt}, 32'(m_pads & 32'hF));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic [7:0] b);
    reset = r; valid = v; in = b;
    @(posedge clk);
    #1;
    model_edge(r, v, b);
    compare_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  b;
    logic [31:0] lanes;   // {out0,out1,out2,out3} after the edge
    logic [3:0]  vo;
    logic [1:0]  sl;
    logic        bz;
  } vec_t;

  vec_t vecs[28];

  task automatic setv(input int i, input logic r, input logic v, input logic [7:0] b,
                      input logic [31:0] lanes, input logic [3:0] vo,
                      input logic [1:0] sl, input logic bz);
    vecs[i].r = r; vecs[i].v = v; vecs[i].b = b;
    vecs[i].lanes = lanes; vecs[i].vo = vo; vecs[i].sl = sl; vecs[i].bz = bz;
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; in = 8'h00;

    //      idx r  v  byte    lanes          vo       sel  busy
    setv(0,  1, 0, 8'h00, 32'h00000000, 4'b0000, 2'd0, 0);
    setv(1,  0, 1, 8'h01, 32'h00000000, 4'b0000, 2'd1, 1);
    setv(2,  0, 1, 8'h02, 32'h00000000, 4'b0000, 2'd2, 1);
    setv(3,  0, 1, 8'h03, 32'h00000000, 4'b0000, 2'd3, 1);
    setv(4,  0, 1, 8'h04, 32'h01020304, 4'b1111, 2'd0, 1);
    setv(5,  0, 1, 8'h05, 32'h01020304, 4'b0000, 2'd1, 1);
    setv(6,  0, 1, 8'h06, 32'h01020304, 4'b0000, 2'd2, 1);
    setv(7,  0, 1, 8'h07, 32'h01020304, 4'b0000, 2'd3, 1);
    setv(8,  0, 1, 8'h08, 32'h05060708, 4'b1111, 2'd0, 1);
    setv(9,  0, 0, 8'h00, 32'h05060708, 4'b0000, 2'd0, 0);
    setv(10, 0, 1, 8'hAA, 32'h05060708, 4'b0000, 2'd1, 1);
    setv(11, 0, 1, 8'hBB, 32'h05060708, 4'b0000, 2'd2, 1);
    setv(12, 0, 1, 8'hCC, 32'h05060708, 4'b0000, 2'd3, 1);
    setv(13, 0, 1, 8'hDD, 32'hAABBCCDD, 4'b1111, 2'd0, 1);
    setv(14, 0, 1, 8'hEE, 32'hAABBCCDD, 4'b0000, 2'd1, 1);
    setv(15, 0, 0, 8'h00, 32'hEEF7F7F7, 4'b0001, 2'd0, 0);
    setv(16, 0, 1, 8'h11, 32'hEEF7F7F7, 4'b0000, 2'd1, 1);
    setv(17, 0, 1, 8'h22, 32'hEEF7F7F7, 4'b0000, 2'd2, 1);
    setv(18, 0, 1, 8'h33, 32'hEEF7F7F7, 4'b0000, 2'd3, 1);
    setv(19, 0, 0, 8'h00, 32'h112233F7, 4'b0111, 2'd0, 0);
    setv(20, 0, 1, 8'h44, 32'h112233F7, 4'b0000, 2'd1, 1);
    setv(21, 0, 1, 8'h55, 32'h112233F7, 4'b0000, 2'd2, 1);
    setv(22, 1, 1, 8'h66, 32'h00000000, 4'b0000, 2'd0, 0);
    setv(23, 0, 1, 8'h01, 32'h00000000, 4'b0000, 2'd1, 1);
    setv(24, 0, 1, 8'h02, 32'h00000000, 4'b0000, 2'd2, 1);
    setv(25, 0, 1, 8'h03, 32'h00000000, 4'b0000, 2'd3, 1);
    setv(26, 0, 1, 8'h04, 32'h01020304, 4'b1111, 2'd0, 1);
    setv(27, 0, 0, 8'h00, 32'h01020304, 4'b0000, 2'd0, 0);

    @(posedge clk); #1;

    for (int i = 0; i < 28; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].b);
      check($sformatf("vec%0d_lanes", i), {out0, out1, out2, out3}, vecs[i].lanes);
      check($sformatf("vec%0d_validout", i), {28'd0, validout}, {28'd0, vecs[i].vo});
      check($sformatf("vec%0d_sel", i), {30'd0, sel}, {30'd0, vecs[i].sl});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].bz});
      if (i == 19) begin
        check("tbl_group_cnt_19", {16'd0, group_cnt}, 32'd5);
        check("tbl_pad_cnt_19", {16'd0, pad_cnt}, 32'd4);
      end
    end
    // Reset in vector 22 discarded 44,55 and both counters.
    check("tbl_group_cnt_end", {16'd0, group_cnt}, 32'd1);
    check("tbl_pad_cnt_end", {16'd0, pad_cnt}, 32'd0);

    // Idle after reset: nothing moves for 20 cycles.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      check("idle_lanes", {out0, out1, out2, out3}, 32'h00000000);
      check("idle_validout", {28'd0, validout}, 32'd0);
    end

    // Counter wrap: 17 full groups on the 4-bit instance wraps to 1.
    step(1'b1, 1'b0, 8'h00);
    for (int g = 0; g < 17; g++)
      for (int j = 0; j < 4; j++)
        step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    step(1'b0, 1'b0, 8'h00);
    check("wrap_group_cnt_w4", {28'd0, n_group_cnt}, 32'd1);
    check("wrap_group_cnt_w16", {16'd0, group_cnt}, 32'd17);
    check("wrap_pad_cnt", {16'd0, pad_cnt}, 32'd0);

    // Random traffic: bursty valid, rare resets, checked every cycle.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 1500; i++) begin
      logic r, v;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(r, v, 8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_stripe_ctrl.md
# lane_stripe_ctrl

Byte-striping controller for the PCIe physical-layer demux path. It sequences a serial byte stream, qualified by `valid`, across four lanes in the fast (4f) clock domain. It collects bytes into a 4-slot staging buffer and launches each complete group onto all four lane outputs in the same cycle, so the lanes stay aligned. A partial group at end of stream is padded and flushed. It sits between the byte source and the per-lane serializers, and replaces the free-running select of the plain 2x4 demux with a framed, flush-capable scheduler.

## Interface
- `PAD_BYTE`, default 8'hF7, byte written into lanes not filled by real data on a flush.
- `CNT_W`, default 16, width of the group and pad counters.
- `clk`  in  1  fast (4f) clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  8  input byte.
- `valid`  in  1  `in` carries a real byte this cycle.
- `out0`..`out3`  out  8 each  lane bytes, registered; hold their value between launches.
- `validout`  out  4  per-lane real-data mask. One-cycle pulse on launch; 0 otherwise.
- `sel`  out  2  next staging slot to be written (0..3).
- `busy`  out  1  1 while the FSM is in FILL.
- `group_cnt`  out  CNT_W  number of groups launched; wraps at 2^CNT_W.
- `pad_cnt`  out  CNT_W  total pad bytes inserted; wraps at 2^CNT_W.

## Operation
- Staging buffer: slots s0..s2 (8 bits each). Slot 3 is never stored; the fourth byte goes straight to `out3` at launch.
- FSM has two states:
  - IDLE: `sel`=0.
  - FILL.
- IDLE, `valid`=1: s0<=`in`, `sel`<=1, go to FILL.
- IDLE, `valid`=0: no change.
- FILL, `valid`=1, `sel`<3: s[sel]<=`in`, `sel`++.
- FILL, `valid`=1, `sel`=3 (full launch):
  - out0..2<=s0..s2, out3<=`in`, `validout`<=4'b1111.
  - `group_cnt`++, `sel`<=0, stay in FILL (supports back-to-back groups).
- FILL, `valid`=0, `sel`=0: go to IDLE; no launch.
- FILL, `valid`=0, `sel`=k (k=1..3), flush launch:
  - lanes 0..k-1<=s0..s(k-1); lanes k..3<=`PAD_BYTE`.
  - `validout`<=(1<<k)-1.
  - `group_cnt`++, `pad_cnt`+=4-k, `sel`<=0, go to IDLE.
- A launch (full or flush) is the only event that updates out0..out3.
- Counters wrap silently with no saturation.
- `busy`=1 exactly when the state is FILL.

## Timing
- Reset values:
  - out0..out3=8'h00, `validout`=4'b0000, `sel`=0, `busy`=0.
  - `group_cnt`=0, `pad_cnt`=0, state IDLE, staging slots 8'h00.
- Reset asserted mid-group discards the partial group with no launch and no pad. Reset takes priority over every other event in the same cycle.
- Full-group latency: the fourth byte sampled at edge N appears on `out3`, with `validout`=4'b1111, after edge N. Bytes 1..3 of the group appear on the same edge.
- Flush latency: the first edge that samples `valid`=0 with `sel`=k>0 produces the flush outputs after that edge.
- `validout` is high for exactly one cycle per launch. It is never high on two consecutive cycles, except during back-to-back full groups (fourth byte of group G followed by fourth byte of group G+1 is at least 4 cycles apart, so never consecutive in practice).
- Gaps within a group are not allowed: `valid` low with `sel`>0 always terminates the group. There is no stall. Throughput is 1 byte/cycle sustained.
- No input is ever dropped. When `valid` rises again the cycle after a flush, that byte goes to s0 of the new group (IDLE handles it).

## Test plan
- Reset, then 8 bytes 01..08 back-to-back -> two launches:
  - 1st: out0..3=01,02,03,04, `validout`=1111.
  - 2nd: out0..3=05..08, `validout`=1111.
  - Final state: `group_cnt`=2, `pad_cnt`=0, FSM back to IDLE one cycle after `valid` drops.
- 5 bytes AA,BB,CC,DD,EE, then `valid`=0:
  - Full group AA..DD.
  - Next cycle flush: out0=EE, out1..3=F7, `validout`=0001.
  - `pad_cnt`=3, `group_cnt`=2.
- Bytes 11,22,33 then `valid`=0:
  - Flush: out=11,22,33,F7, `validout`=0111, `pad_cnt`=1.
  - Then `valid`=1 with 44 the next cycle -> `sel`=1, `busy`=1, no launch.
- Bytes 01,02 then `reset`=1 for one cycle -> no `validout` pulse; all outputs and counters 0; the next 4 bytes launch as a clean group starting at out0.
- `valid` held low after reset for 20 cycles -> `validout`=0, `sel`=0, `busy`=0, out0..3=00 throughout.
- CNT_W=4, 17 full groups -> `group_cnt` wraps to 1.
